// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture/playback path: sample geometry,
// DAC mid-scale code, playback FSM states and the read tag that rides
// alongside each RAM read.
package scope_pkg;

   localparam int SAMPLES = 160;
   localparam int ADC_W   = 14;

   // Offset-binary zero: what the DAC sits at whenever no sample is playing.
   localparam logic [ADC_W-1:0] MIDSCALE = 14'h2000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   // Travels with a RAM read so the output stage knows whether the returning
   // word is a real sample and whether it opens or closes a pass.
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } rd_tag_t;

endpackage

// File: rtl/ramplay_pipe.sv
// Delay line for read tags. Its depth equals the RAM read latency, so the tag
// leaving the last stage lines up with the rd_data word it describes.
module ramplay_pipe
   import scope_pkg::*;
#(
   parameter int LAT = 1
)(
   input  logic    clk_adc,
   input  logic    reset,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag,
   output logic    o_empty
);

   rd_tag_t r_stage [LAT];

   // Shift one stage per cycle; reset drops every read still in flight.
   always_ff @(posedge clk_adc) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < LAT; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[LAT-1];

   // The pipe is empty once no stage holds a valid read.
   always_comb begin
      o_empty = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         if (r_stage[i].valid) begin
            o_empty = 1'b0;
         end
      end
   end

endmodule

// File: rtl/ramplay_dac.sv
// Playback side of the capture RAM: reads DEPTH samples per pass and streams
// them to the DAC one per clk_adc, with a trigger marker on sample 0, optional
// looping with an idle gap, and a pass-complete toggle for the VGA domain.
//
// RAM read contract: rd_en high in a cycle issues rd_addr; the RAM presents
// that word on rd_data exactly RD_LAT cycles later. There is no back-pressure,
// the RAM must accept one read per cycle, and rd_data is ignored whenever the
// matching tag is not valid.
//
// done_tgl is the only signal consumed in another clock domain. It changes
// once per pass and is held for a whole pass, so a 2-flop synchroniser plus an
// XOR edge detector on the VGA side cannot miss or double count a pass.
module ramplay_dac
   import scope_pkg::*;
#(
   parameter int DEPTH  = SAMPLES,
   parameter int AW     = 8,
   parameter int DW     = ADC_W,
   parameter int RD_LAT = 1,
   parameter int GAP    = 0
)(
   input  logic          clk_adc,
   input  logic          reset,
   input  logic          enable,
   input  logic          loop,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic [DW-1:0] dac_data,
   output logic          dac_valid,
   output logic          trig_out,
   output logic          busy,
   output logic          done_tgl,
   output state_t        o_dbg_state
);

   // Gap counter must hold GAP (up to 255) plus the drain cycles (up to 5).
   localparam int GAP_W = 9;
   localparam logic [GAP_W-1:0] GAP_CNT   = GAP_W'(GAP);
   localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [DW-1:0]    MID_CODE  = DW'(MIDSCALE);
   localparam bit               NO_GAP    = (GAP == 0);

   state_t           r_state;
   state_t           w_next;
   logic             r_enable_q;
   logic [AW-1:0]    r_addr;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [GAP_W-1:0] w_gap_n;
   logic             w_start;
   logic             w_at_last;
   logic             w_cont;
   logic             w_rd_en;
   logic             w_pipe_empty;
   rd_tag_t          w_tag_in;
   rd_tag_t          w_tag_out;
   logic [DW-1:0]    r_dac_data;
   logic             r_dac_valid;
   logic             r_trig;
   logic             r_dac_last;
   logic             r_done_tgl;

   // Only a rising edge seen while idle starts playback.
   assign w_start   = enable & ~r_enable_q & (r_state == ST_IDLE);
   assign w_at_last = (r_addr == LAST_ADDR);
   assign w_cont    = loop & enable;
   // Number of the current non-PLAY cycle since the pass ended (1 = first).
   assign w_gap_n   = r_gap_cnt + GAP_W'(1);

   // Register enable every cycle for edge detection.
   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_enable_q <= 1'b0;
      end else begin
         r_enable_q <= enable;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and read strobe. The GAP state ends once the total count of
   // non-PLAY cycles since the pass ended reaches GAP, so the DAC sees exactly
   // GAP idle cycles between passes whenever GAP covers the drain time; it
   // always lasts at least one cycle.
   always_comb begin
      w_next  = r_state;
      w_rd_en = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_next = ST_PLAY;
            end
         end
         ST_PLAY: begin
            w_rd_en = 1'b1;
            if (w_at_last) begin
               w_next = (w_cont && NO_GAP) ? ST_PLAY : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_pipe_empty) begin
               w_next = (w_cont && !NO_GAP) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (w_gap_n >= GAP_CNT) begin
               w_next = enable ? ST_PLAY : ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Address counter: advances in PLAY, wraps DEPTH-1 -> 0, rests at 0.
   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_addr <= '0;
      end else if (r_state == ST_PLAY) begin
         r_addr <= w_at_last ? '0 : r_addr + AW'(1);
      end else begin
         r_addr <= '0;
      end
   end

   // Counts non-PLAY cycles between passes while draining or gapping.
   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_gap_cnt <= '0;
      end else if (r_state == ST_DRAIN || r_state == ST_GAP) begin
         r_gap_cnt <= w_gap_n;
      end else begin
         r_gap_cnt <= '0;
      end
   end

   assign w_tag_in.valid = w_rd_en;
   assign w_tag_in.first = w_rd_en & (r_addr == '0);
   assign w_tag_in.last  = w_rd_en & w_at_last;

   ramplay_pipe #(
      .LAT (RD_LAT)
   ) u_pipe (
      .clk_adc (clk_adc),
      .reset   (reset),
      .i_tag   (w_tag_in),
      .o_tag   (w_tag_out),
      .o_empty (w_pipe_empty)
   );

   // DAC output register: a tagged word becomes a played sample, anything
   // else parks the DAC at mid-scale.
   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_dac_data  <= MID_CODE;
         r_dac_valid <= 1'b0;
         r_trig      <= 1'b0;
         r_dac_last  <= 1'b0;
      end else if (w_tag_out.valid) begin
         r_dac_data  <= rd_data;
         r_dac_valid <= 1'b1;
         r_trig      <= w_tag_out.first;
         r_dac_last  <= w_tag_out.last;
      end else begin
         r_dac_data  <= MID_CODE;
         r_dac_valid <= 1'b0;
         r_trig      <= 1'b0;
         r_dac_last  <= 1'b0;
      end
   end

   // Flip the pass toggle the cycle after the last sample is on the DAC.
   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_done_tgl <= 1'b0;
      end else if (r_dac_last) begin
         r_done_tgl <= ~r_done_tgl;
      end
   end

   assign rd_en       = w_rd_en;
   assign rd_addr     = r_addr;
   assign dac_data    = r_dac_data;
   assign dac_valid   = r_dac_valid;
   assign trig_out    = r_trig;
   assign busy        = (r_state != ST_IDLE);
   assign done_tgl    = r_done_tgl;
   assign o_dbg_state = r_state;

endmodule
